// File: rtl/qalu_pkg.sv
// Shared types and constants for the sequential sign-magnitude Q-format ALU.
package qalu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } qalu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } qalu_state_e;

  // Largest representable magnitude of an n-bit sign-magnitude word.
  function automatic logic [63:0] qalu_sat_mag(input int unsigned n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/qalu_addsub.sv
// Combinational sign-magnitude add/subtract with saturation; zero is always +0.
module qalu_addsub
  import qalu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] res,
  output logic         ovf
);

  localparam int M = N - 1;
  localparam logic [M-1:0] SAT = M'(qalu_sat_mag(N));

  logic         sa, sb, sgn;
  logic [M-1:0] ma, mb, mag;
  logic [M:0]   sum;

  always_comb begin
    sa  = a[N-1];
    sb  = b[N-1] ^ sub;
    ma  = a[M-1:0];
    mb  = b[M-1:0];
    sum = {1'b0, ma} + {1'b0, mb};
    ovf = 1'b0;
    sgn = sa;
    mag = '0;
    if (sa == sb) begin
      // Only like signs can carry out; the saturated value keeps that shared sign.
      if (sum[M]) begin
        mag = SAT;
        ovf = 1'b1;
      end else begin
        mag = sum[M-1:0];
      end
    end else if (ma >= mb) begin
      mag = ma - mb;
    end else begin
      mag = mb - ma;
      sgn = sb;
    end
    if (mag == '0) sgn = 1'b0;
    res = {sgn, mag};
  end

endmodule

// File: rtl/qalu_seq.sv
// Sequential Q-format ALU: single-cycle add/sub, shift-add multiply and
// restoring divide behind one start/done handshake, with saturation.
module qalu_seq
  import qalu_pkg::*;
#(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         ovf,
  output logic         div0
);

  localparam int M  = N - 1;
  localparam int W  = M + Q;
  localparam int CW = $clog2(N + Q);
  localparam logic [M-1:0]  SAT      = M'(qalu_sat_mag(N));
  localparam logic [CW-1:0] MUL_LAST = CW'(M - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(W - 1);

  qalu_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [N-1:0]    result_q, result_d;
  logic            ovf_q, ovf_d;
  logic            div0_q, div0_d;

  logic            sgn_q, sgn_d;
  logic [2*M-1:0]  mcand_q, mcand_d;
  logic [M-1:0]    mplier_q, mplier_d;
  logic [2*M-1:0]  prod_q, prod_d;
  logic [W-1:0]    dq_q, dq_d;
  logic [M-1:0]    rem_q, rem_d;
  logic [M-1:0]    divisor_q, divisor_d;

  logic [2*M-1:0]  prod_nx, prod_sh;
  logic [M:0]      trial;
  logic            qbit;
  logic [W-1:0]    dq_nx;
  logic [N-1:0]    as_res;
  logic            as_ovf;

  qalu_addsub #(.N(N)) u_addsub (
    .a   (a),
    .b   (b),
    .sub (op == OP_SUB),
    .res (as_res),
    .ovf (as_ovf)
  );

  function automatic logic [N-1:0] pack_sm(input logic s, input logic [M-1:0] m);
    return {s & (m != '0), m};
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    result_d  = result_q;
    ovf_d     = ovf_q;
    div0_d    = div0_q;
    sgn_d     = sgn_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    dq_d      = dq_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;

    prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);
    prod_sh = prod_nx >> Q;
    // Restoring step: dividend bits stream out of the top of dq while quotient bits enter at the bottom.
    trial   = {rem_q, dq_q[W-1]};
    qbit    = (trial >= {1'b0, divisor_q});
    dq_nx   = {dq_q[W-2:0], qbit};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ovf_d  = 1'b0;
          div0_d = 1'b0;
          sgn_d  = a[N-1] ^ b[N-1];
          cnt_d  = '0;
          case (qalu_op_e'(op))
            OP_ADD, OP_SUB: begin
              result_d = as_res;
              ovf_d    = as_ovf;
              done_d   = 1'b1;
            end
            OP_MUL: begin
              mcand_d  = {{M{1'b0}}, a[M-1:0]};
              mplier_d = b[M-1:0];
              prod_d   = '0;
              state_d  = ST_MUL;
            end
            default: begin
              if (b[M-1:0] == '0) begin
                result_d = {a[N-1] ^ b[N-1], SAT};
                div0_d   = 1'b1;
                done_d   = 1'b1;
              end else begin
                dq_d      = {a[M-1:0], {Q{1'b0}}};
                rem_d     = '0;
                divisor_d = b[M-1:0];
                state_d   = ST_DIV;
              end
            end
          endcase
        end
      end
      ST_MUL: begin
        prod_d   = prod_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == MUL_LAST) begin
          if (|prod_sh[2*M-1:M]) begin
            result_d = pack_sm(sgn_q, SAT);
            ovf_d    = 1'b1;
          end else begin
            result_d = pack_sm(sgn_q, prod_sh[M-1:0]);
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        dq_d  = dq_nx;
        rem_d = qbit ? M'(trial - {1'b0, divisor_q}) : trial[M-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) begin
          if (|dq_nx[W-1:M]) begin
            result_d = pack_sm(sgn_q, SAT);
            ovf_d    = 1'b1;
          end else begin
            result_d = pack_sm(sgn_q, dq_nx[M-1:0]);
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      div0_q   <= div0_d;
    end
  end

  // Working registers are always reloaded on accept, so they need no reset.
  always_ff @(posedge clk) begin
    sgn_q     <= sgn_d;
    mcand_q   <= mcand_d;
    mplier_q  <= mplier_d;
    prod_q    <= prod_d;
    dq_q      <= dq_d;
    rem_q     <= rem_d;
    divisor_q <= divisor_d;
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign div0   = div0_q;

endmodule

// File: tb/tb_qalu_seq.sv
// Self-checking bench for qalu_seq: directed cases plus randomized ops against an arithmetic model.
module tb_qalu_seq;

  localparam int Q = 15;
  localparam int N = 32;
  localparam longint SATV = (64'sd1 <<< (N - 1)) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, ovf, div0;
  logic [31:0] result;

  int n_chk = 0;
  int n_pass = 0;

  qalu_seq #(.Q(Q), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference: operate on real signed values of the Q-format words.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic v, output logic z);
    longint ma, mb, va, vb, sum, mag;
    logic s;
    ma = longint'(x[30:0]);
    mb = longint'(y[30:0]);
    v = 1'b0;
    z = 1'b0;
    s = x[31] ^ y[31];
    mag = 0;
    if (o == 2'd0 || o == 2'd1) begin
      va  = x[31] ? -ma : ma;
      vb  = (y[31] ^ (o == 2'd1)) ? -mb : mb;
      sum = va + vb;
      s   = (sum < 0);
      mag = s ? -sum : sum;
    end else if (o == 2'd2) begin
      mag = (ma * mb) >>> Q;
    end else if (mb == 0) begin
      z = 1'b1;
      mag = SATV;
    end else begin
      mag = (ma <<< Q) / mb;
    end
    if (mag > SATV) begin
      mag = SATV;
      v = 1'b1;
    end
    if (mag == 0) s = 1'b0;
    r = {s, mag[30:0]};
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
    if (o == 2'd2) return N - 1;
    if (o == 2'd3 && y[30:0] != 0) return N - 1 + Q;
    return 0;
  endfunction

  // Accept one op, scramble inputs, and count edges after the accept edge until done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int k);
    int guard = 0;
    while (busy && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    k = 0;
    while (!done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_dir(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic ev, input logic ez);
    int k;
    do_op(o, x, y, k);
    check({tag, ".lat"}, 32'(k), 32'(exp_lat(o, y)));
    check({tag, ".res"}, result, er);
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, ev});
    check({tag, ".div0"}, {31'd0, div0}, {31'd0, ez});
  endtask

  initial begin
    int k, hi;
    logic [31:0] er, x, y;
    logic ev, ez;
    logic [1:0] o;

    repeat (3) @(posedge clk);
    #1;
    check("rst.result", result, 32'h0);
    check("rst.flags", {28'd0, busy, done, ovf, div0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_dir("add", 2'd0, 32'h0000C000, 32'h00012000, 32'h0001E000, 1'b0, 1'b0);
    check("add.busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("add.done_drop", {31'd0, done}, 32'd0);
    run_dir("sub", 2'd1, 32'h0000C000, 32'h00012000, 32'h80006000, 1'b0, 1'b0);
    run_dir("addz", 2'd0, 32'h0000C000, 32'h8000C000, 32'h00000000, 1'b0, 1'b0);
    run_dir("subz", 2'd1, 32'h8000C000, 32'h8000C000, 32'h00000000, 1'b0, 1'b0);
    run_dir("mul", 2'd2, 32'h0000C000, 32'h80012000, 32'h8001B000, 1'b0, 1'b0);
    run_dir("div", 2'd3, 32'h0001E000, 32'h0000C000, 32'h00014000, 1'b0, 1'b0);
    run_dir("div0", 2'd3, 32'h00010000, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
    run_dir("addsat", 2'd0, 32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0);
    run_dir("subsat", 2'd1, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_dir("mulsat", 2'd2, 32'h40000000, 32'h40000000, 32'h7FFFFFFF, 1'b1, 1'b0);
    run_dir("divsat", 2'd3, 32'h40000000, 32'h80000001, 32'hFFFFFFFF, 1'b1, 1'b0);

    // start mid-MUL must be ignored
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 32'h0000C000; b = 32'h80012000;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign.busy", {31'd0, busy}, 32'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'h00001234; b = 32'h00004321;
    @(posedge clk); #1;
    start = 1'b0;
    k = 10;
    while (!done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("ign.lat", 32'(k), 32'd31);
    check("ign.res", result, 32'h8001B000);

    // asynchronous reset in the middle of a DIV
    run_dir("pre", 2'd2, 32'h40000000, 32'h40000000, 32'h7FFFFFFF, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 2'd3; a = 32'h0001E000; b = 32'h0000C000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.result", result, 32'h0);
    check("arst.flags", {28'd0, busy, done, ovf, div0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_dir("post", 2'd0, 32'h0000C000, 32'h00012000, 32'h0001E000, 1'b0, 1'b0);

    // randomized, back-to-back
    for (int i = 0; i < 60; i++) begin
      o  = 2'($urandom);
      hi = int'($urandom_range(0, 30));
      x  = $urandom >> hi;
      x[31] = $urandom_range(0, 1) == 1;
      hi = int'($urandom_range(0, 30));
      y  = $urandom >> hi;
      y[31] = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) y[30:0] = '0;
      model(o, x, y, er, ev, ez);
      run_dir($sformatf("rnd%0d", i), o, x, y, er, ev, ez);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
